// File: rtl/imem_refill_ctrl.sv
// Refill responder for the 2-way multiword instruction cache.
// On a cache miss it fetches the 64-bit line from instruction memory one word at a
// time over a req/ack interface, then hands the line to the cache as a one-cycle
// Access_MM pulse. It also counts delivered and dropped refills.
module imem_refill_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 20
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HitWrite,
  input  logic              NOT_JUMPED,
  input  logic [ADDR_W-1:0] PC,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_RDATA,
  output logic              Access_MM,
  output logic [63:0]       Data_MM,
  output logic              BUSY,
  output logic [CNT_W-1:0]  CNT_REFILL,
  output logic [CNT_W-1:0]  CNT_ABORT
);

  typedef enum logic [1:0] {
    StIdle,
    StRd0,
    StRd1,
    StDeliver
  } state_t;

  localparam logic [ADDR_W-1:0] WordBytes = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] line;
  logic              drop;

  // Line base of the missing fetch address; the byte offset within the line is irrelevant.
  logic [ADDR_W-1:0] line_base;
  logic [2:0]        unused_pc_offset;
  assign line_base        = {PC[ADDR_W-1:3], 3'b000};
  assign unused_pc_offset = PC[2:0];

  // A jump seen in the same cycle as the final ack must also suppress delivery.
  logic stale;
  assign stale = drop | ~NOT_JUMPED;

  // Refill FSM; every output is a register updated here.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= StIdle;
      line       <= '0;
      drop       <= 1'b0;
      MEM_REQ    <= 1'b0;
      MEM_ADDR   <= '0;
      Access_MM  <= 1'b0;
      Data_MM    <= '0;
      BUSY       <= 1'b0;
      CNT_REFILL <= '0;
      CNT_ABORT  <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (!HitWrite && NOT_JUMPED) begin
            line     <= line_base;
            drop     <= 1'b0;
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= line_base;
            BUSY     <= 1'b1;
            state    <= StRd0;
          end
        end

        StRd0: begin
          if (!NOT_JUMPED) begin
            drop <= 1'b1;
          end
          // The request stays up until acknowledged, even if the line went stale.
          if (MEM_ACK) begin
            Data_MM[63:32] <= MEM_RDATA;
            MEM_ADDR       <= line + WordBytes;
            state          <= StRd1;
          end
        end

        StRd1: begin
          if (!NOT_JUMPED) begin
            drop <= 1'b1;
          end
          if (MEM_ACK) begin
            Data_MM[31:0] <= MEM_RDATA;
            MEM_REQ       <= 1'b0;
            if (stale) begin
              CNT_ABORT <= CNT_ABORT + CntOne;
              BUSY      <= 1'b0;
              state     <= StIdle;
            end else begin
              Access_MM <= 1'b1;
              state     <= StDeliver;
            end
          end
        end

        StDeliver: begin
          Access_MM  <= 1'b0;
          CNT_REFILL <= CNT_REFILL + CntOne;
          BUSY       <= 1'b0;
          state      <= StIdle;
        end

        default: begin
          MEM_REQ   <= 1'b0;
          Access_MM <= 1'b0;
          BUSY      <= 1'b0;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule
